// File: rtl/clbalup.sv
// clbalup: parametrised, pipelined CLB ALU tile.
//   Modes (MODE_ALU): 0 pass-through of I0, 1 add/sub I0 +/- I1, 2 accumulate
//   +/- I0. Signed overflow detection with optional saturation (SAT=1). The
//   result latency is PIPE edges (1 or 2). CTRL[3] HOLD freezes every register.
// Ports:
//   C     clock, rising edge
//   R     asynchronous active-low reset; clears every register
//   I1    operand B (mode 1)
//   I0    operand A (modes 0, 1, 2)
//   CTRL  [0] SUB, [1] CINEN, [2] ACLR, [3] HOLD, [7:4] reserved
//   CIN   carry in from the previous tile (used when CINEN=1)
//   VIN   operands valid this cycle
//   COUT  carry out of bit WIDTH-1 of the last beat
//   OVF   signed overflow (sticky in mode 2 until an ACLR beat)
//   VOUT  Q/COUT/OVF valid
//   Q     result (accumulator value in mode 2)
module clbalup #(
  parameter int WIDTH    = 16,
  parameter int MODE_ALU = 1,
  parameter int PIPE     = 1,
  parameter int SAT      = 0
) (
  input  logic             C,
  input  logic             R,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I0,
  input  logic [7:0]       CTRL,
  input  logic             CIN,
  input  logic             VIN,
  output logic             COUT,
  output logic             OVF,
  output logic             VOUT,
  output logic [WIDTH-1:0] Q
);

  localparam int MSB = WIDTH - 1;

  // On overflow both operands share a sign, so the operand sign is the sign
  // of the true (unbounded) result.
  function automatic logic [WIDTH-1:0] sat_fn(input logic [WIDTH-1:0] val,
                                              input logic             ovf,
                                              input logic             neg);
    sat_fn = val;
    if ((SAT != 0) && ovf) begin
      sat_fn = neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  endfunction

  logic sub, cinen, aclr, hold, cin_eff;
  logic ctrl_unused;

  assign sub         = CTRL[0];
  assign cinen       = CTRL[1];
  assign aclr        = CTRL[2];
  assign hold        = CTRL[3];
  assign cin_eff     = cinen ? CIN : sub;
  assign ctrl_unused = ^CTRL[7:4];

  logic signed [WIDTH-1:0] opa, opb;
  logic        [WIDTH:0]   sum_w;
  logic                    ovf_raw;
  logic        [WIDTH-1:0] res_raw;

  logic [WIDTH-1:0] res_p1_q, res_p1_d;
  logic             cout_p1_q, cout_p1_d;
  logic             ovf_p1_q, ovf_p1_d;
  logic             vld_p1_q, vld_p1_d;

  // ---- stage 1: operand select, add, overflow/saturate, accumulator ----
  always_comb begin
    opa = '0;
    opb = '0;
    if (MODE_ALU == 2) begin
      // res_p1_q doubles as the accumulator, so a back-to-back beat always
      // sees the value written by the previous beat.
      opa = aclr ? '0 : res_p1_q;
      opb = sub ? ~I0 : I0;
    end else begin
      opa = I0;
      opb = sub ? ~I1 : I1;
    end
    sum_w   = {1'b0, opa} + {1'b0, opb} + {{WIDTH{1'b0}}, cin_eff};
    ovf_raw = (opa[MSB] == opb[MSB]) && (sum_w[MSB] != opa[MSB]);
    res_raw = sat_fn(sum_w[MSB:0], ovf_raw, opa[MSB]);

    res_p1_d  = res_p1_q;
    cout_p1_d = cout_p1_q;
    ovf_p1_d  = ovf_p1_q;
    vld_p1_d  = vld_p1_q;
    if (!hold) begin
      vld_p1_d = VIN;
      if (VIN) begin
        if (MODE_ALU == 0) begin
          res_p1_d  = I0;
          cout_p1_d = 1'b0;
          ovf_p1_d  = 1'b0;
        end else if (MODE_ALU == 2) begin
          res_p1_d  = res_raw;
          cout_p1_d = sum_w[WIDTH];
          ovf_p1_d  = (ovf_p1_q & ~aclr) | ovf_raw;
        end else begin
          res_p1_d  = res_raw;
          cout_p1_d = sum_w[WIDTH];
          ovf_p1_d  = ovf_raw;
        end
      end
    end
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      res_p1_q  <= '0;
      cout_p1_q <= 1'b0;
      ovf_p1_q  <= 1'b0;
      vld_p1_q  <= 1'b0;
    end else begin
      res_p1_q  <= res_p1_d;
      cout_p1_q <= cout_p1_d;
      ovf_p1_q  <= ovf_p1_d;
      vld_p1_q  <= vld_p1_d;
    end
  end

  // ---- stage 2 (PIPE=2 only): output delay register ----
  generate
    if (PIPE == 2) begin : g_p2
      logic [WIDTH-1:0] res_p2_q, res_p2_d;
      logic             cout_p2_q, cout_p2_d;
      logic             ovf_p2_q, ovf_p2_d;
      logic             vld_p2_q, vld_p2_d;

      always_comb begin
        res_p2_d  = res_p2_q;
        cout_p2_d = cout_p2_q;
        ovf_p2_d  = ovf_p2_q;
        vld_p2_d  = vld_p2_q;
        if (!hold) begin
          vld_p2_d = vld_p1_q;
          // Data only advances with a valid beat so Q keeps its last value.
          if (vld_p1_q) begin
            res_p2_d  = res_p1_q;
            cout_p2_d = cout_p1_q;
            ovf_p2_d  = ovf_p1_q;
          end
        end
      end

      always_ff @(posedge C or negedge R) begin
        if (!R) begin
          res_p2_q  <= '0;
          cout_p2_q <= 1'b0;
          ovf_p2_q  <= 1'b0;
          vld_p2_q  <= 1'b0;
        end else begin
          res_p2_q  <= res_p2_d;
          cout_p2_q <= cout_p2_d;
          ovf_p2_q  <= ovf_p2_d;
          vld_p2_q  <= vld_p2_d;
        end
      end

      assign Q    = res_p2_q;
      assign COUT = cout_p2_q;
      assign OVF  = ovf_p2_q;
      assign VOUT = vld_p2_q;
    end else begin : g_p1
      assign Q    = res_p1_q;
      assign COUT = cout_p1_q;
      assign OVF  = ovf_p1_q;
      assign VOUT = vld_p1_q;
    end
  endgenerate

endmodule

// File: tb/tb_clbalup.sv
// tb_clbalup: six clbalup configurations share one random stimulus stream and
// are compared every cycle against an arithmetic model; a pair of mode-1 tiles
// is chained through COUT/CIN to form 32-bit add/sub.
module tb_clbalup;
  localparam int W = 16;
  localparam int N = 6;
  // Per-instance config, index g: g0 m0/p1, g1 m1/p1, g2 m1/p1/sat,
  // g3 m1/p2/sat, g4 m2/p1, g5 m2/p2/sat.
  localparam logic [2*N-1:0] MDS = {2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd0};
  localparam logic [2*N-1:0] PPS = {2'd2, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1};
  localparam logic [N-1:0]   STS = 6'b101100;

  logic         clk, rst_n;
  logic [W-1:0] i0, i1;
  logic [7:0]   ctrl;
  logic         cin, vin;
  logic [W-1:0] q    [N];
  logic         cout [N];
  logic         ovf  [N];
  logic         vout [N];

  logic [W-1:0] lo_i0, lo_i1, hi_i0, hi_i1, lo_q, hi_q;
  logic [7:0]   lo_ctrl, hi_ctrl;
  logic         lo_vin, hi_vin, lo_cout, hi_cout, lo_ovf, hi_ovf, lo_vout, hi_vout;

  int n_vec = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    clbalup #(
      .WIDTH(W), .MODE_ALU(int'(MDS[2*g +: 2])),
      .PIPE(int'(PPS[2*g +: 2])), .SAT(int'(STS[g]))
    ) u_dut (
      .C(clk), .R(rst_n), .I1(i1), .I0(i0), .CTRL(ctrl), .CIN(cin), .VIN(vin),
      .COUT(cout[g]), .OVF(ovf[g]), .VOUT(vout[g]), .Q(q[g])
    );
  end

  clbalup #(.WIDTH(W), .MODE_ALU(1), .PIPE(1), .SAT(0)) u_lo (
    .C(clk), .R(rst_n), .I1(lo_i1), .I0(lo_i0), .CTRL(lo_ctrl), .CIN(1'b0),
    .VIN(lo_vin), .COUT(lo_cout), .OVF(lo_ovf), .VOUT(lo_vout), .Q(lo_q)
  );

  clbalup #(.WIDTH(W), .MODE_ALU(1), .PIPE(1), .SAT(0)) u_hi (
    .C(clk), .R(rst_n), .I1(hi_i1), .I0(hi_i0), .CTRL(hi_ctrl), .CIN(lo_cout),
    .VIN(hi_vin), .COUT(hi_cout), .OVF(hi_ovf), .VOUT(hi_vout), .Q(hi_q)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int sx(input int x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  // One beat from the arithmetic rules: true signed sum decides overflow.
  function automatic void beat(input int md, input bit sat,
                               input logic [W-1:0] a0, input logic [W-1:0] a1,
                               input logic [7:0] ct, input logic ci,
                               input logic [W-1:0] acc_in, input bit ovs_in,
                               output logic [W-1:0] q_o, output bit c_o, output bit o_o,
                               output logic [W-1:0] acc_o, output bit ovs_o);
    logic [W-1:0] opv;
    int base, opr, cn, us, ss;
    bit ovr;
    acc_o = acc_in;
    ovs_o = ovs_in;
    if (md == 0) begin
      q_o = a0; c_o = 1'b0; o_o = 1'b0;
      return;
    end
    cn   = ct[1] ? int'(ci) : int'(ct[0]);
    opv  = (md == 1) ? a1 : a0;
    if (ct[0]) opv = ~opv;
    opr  = int'(opv);
    base = (md == 1) ? int'(a0) : (ct[2] ? 0 : int'(acc_in));
    us   = base + opr + cn;
    ss   = sx(base) + sx(opr) + cn;
    ovr  = (ss > 32767) || (ss < -32768);
    c_o  = us[16];
    q_o  = (ovr && sat) ? ((ss > 0) ? 16'h7FFF : 16'h8000) : us[15:0];
    if (md == 2) begin
      acc_o = q_o;
      ovs_o = (ct[2] ? 1'b0 : ovs_in) | ovr;
      o_o   = ovs_o;
    end else begin
      o_o = ovr;
    end
  endfunction

  // Model state: accumulator, sticky flag, one pending beat for PIPE=2,
  // and the expected visible outputs.
  logic [W-1:0] m_acc [N];
  logic         m_ovs [N];
  logic         p_v [N], p_c [N], p_o [N];
  logic [W-1:0] p_q [N];
  logic         e_v [N], e_c [N], e_o [N];
  logic [W-1:0] e_q [N];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < N; g++) begin
        m_acc[g] <= '0; m_ovs[g] <= 1'b0;
        p_v[g] <= 1'b0; p_c[g] <= 1'b0; p_o[g] <= 1'b0; p_q[g] <= '0;
        e_v[g] <= 1'b0; e_c[g] <= 1'b0; e_o[g] <= 1'b0; e_q[g] <= '0;
      end
    end else if (!ctrl[3]) begin
      for (int g = 0; g < N; g++) begin
        automatic logic [W-1:0] bq = '0;
        automatic logic [W-1:0] na = m_acc[g];
        automatic bit bc = 1'b0, bo = 1'b0, nov = m_ovs[g];
        if (vin) begin
          beat(int'(MDS[2*g +: 2]), STS[g], i0, i1, ctrl, cin, m_acc[g], m_ovs[g],
               bq, bc, bo, na, nov);
          m_acc[g] <= na;
          m_ovs[g] <= nov;
        end
        if (PPS[2*g +: 2] == 2'd1) begin
          e_v[g] <= vin;
          if (vin) begin e_q[g] <= bq; e_c[g] <= bc; e_o[g] <= bo; end
        end else begin
          e_v[g] <= p_v[g];
          if (p_v[g]) begin e_q[g] <= p_q[g]; e_c[g] <= p_c[g]; e_o[g] <= p_o[g]; end
          p_v[g] <= vin;
          if (vin) begin p_q[g] <= bq; p_c[g] <= bc; p_o[g] <= bo; end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < N; g++) begin
      check($sformatf("g%0d Q", g), 32'(q[g]), 32'(e_q[g]));
      check($sformatf("g%0d COUT", g), 32'(cout[g]), 32'(e_c[g]));
      check($sformatf("g%0d OVF", g), 32'(ovf[g]), 32'(e_o[g]));
      check($sformatf("g%0d VOUT", g), 32'(vout[g]), 32'(e_v[g]));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] corner [5];
    corner = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
    return W'($urandom);
  endfunction

  task automatic chain(input logic [31:0] a, input logic [31:0] b, input bit sb);
    logic [32:0] full;
    lo_i0 = a[15:0]; lo_i1 = b[15:0]; lo_ctrl = {7'd0, sb}; lo_vin = 1'b1; hi_vin = 1'b0;
    tick();
    lo_vin = 1'b0;
    hi_i0 = a[31:16]; hi_i1 = b[31:16]; hi_ctrl = {6'd0, 1'b1, sb}; hi_vin = 1'b1;
    tick();
    hi_vin = 1'b0;
    full = sb ? ({1'b0, a} + {1'b0, ~b} + 33'd1) : ({1'b0, a} + {1'b0, b});
    check("chain sum", {hi_q, lo_q}, full[31:0]);
    check("chain cout", 32'(hi_cout), 32'(full[32]));
  endtask

  localparam logic [W-1:0] HQ [8] = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd2, 16'd3, 16'd4, 16'd4};
  localparam logic         HV [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; i0 = '0; i1 = '0; ctrl = '0; cin = 1'b0; vin = 1'b0;
    lo_i0 = '0; lo_i1 = '0; hi_i0 = '0; hi_i1 = '0;
    lo_ctrl = '0; hi_ctrl = '0; lo_vin = 1'b0; hi_vin = 1'b0;
    @(negedge clk);
    for (int g = 0; g < N; g++) begin
      check("reset Q", 32'(q[g]), 32'h0);
      check("reset VOUT", 32'(vout[g]), 32'h0);
    end
    rst_n = 1'b1;

    // Add overflow
    ctrl = 8'h00; i0 = 16'h7FFF; i1 = 16'h0001; vin = 1'b1;
    tick();
    check("addovf Q", 32'(q[1]), 32'h8000);
    check("addovf OVF", 32'(ovf[1]), 32'h1);
    check("addovf COUT", 32'(cout[1]), 32'h0);
    check("addovf VOUT", 32'(vout[1]), 32'h1);
    check("addovf sat Q", 32'(q[2]), 32'h7FFF);

    // Subtract with borrow
    ctrl = 8'h01; i0 = 16'h0005; i1 = 16'h0007;
    tick();
    check("sub Q", 32'(q[1]), 32'hFFFE);
    check("sub COUT", 32'(cout[1]), 32'h0);
    check("sub OVF", 32'(ovf[1]), 32'h0);
    i0 = 16'h0009;
    tick();
    check("sub2 Q", 32'(q[1]), 32'h0002);
    check("sub2 COUT", 32'(cout[1]), 32'h1);

    // Accumulate with sticky overflow
    ctrl = 8'h04; i0 = 16'd3; tick(); check("acc 3", 32'(q[4]), 32'd3);
    ctrl = 8'h00; i0 = 16'd4; tick(); check("acc 7", 32'(q[4]), 32'd7);
    i0 = 16'd5; tick(); check("acc 12", 32'(q[4]), 32'd12);
    i0 = 16'h7FFF; tick();
    check("acc ovf Q", 32'(q[4]), 32'h800B);
    check("acc ovf", 32'(ovf[4]), 32'h1);
    i0 = 16'd1; tick();
    check("acc sticky", 32'(ovf[4]), 32'h1);
    ctrl = 8'h04; i0 = 16'd2; tick();
    check("acc clr Q", 32'(q[4]), 32'd2);
    check("acc clr ovf", 32'(ovf[4]), 32'h0);

    // HOLD stall on the PIPE=2 add tile
    ctrl = 8'h00; i1 = 16'd0; i0 = 16'd1; vin = 1'b1; tick();
    for (int k = 0; k < 8; k++) begin
      vin = 1'b1; ctrl = 8'h00;
      if (k == 0) i0 = 16'd2;
      else if (k < 4) begin ctrl = 8'h08; i0 = 16'd99; end
      else if (k == 4) i0 = 16'd3;
      else if (k == 5) i0 = 16'd4;
      else vin = 1'b0;
      tick();
      check($sformatf("hold Q%0d", k), 32'(q[3]), 32'(HQ[k]));
      check($sformatf("hold V%0d", k), 32'(vout[3]), 32'(HV[k]));
    end

    // Asynchronous reset mid-stream
    ctrl = 8'h00; i0 = 16'd5; vin = 1'b1;
    tick(); tick();
    @(posedge clk); #2; rst_n = 1'b0; #1;
    for (int g = 0; g < N; g++) begin
      check("areset Q", 32'(q[g]), 32'h0);
      check("areset VOUT", 32'(vout[g]), 32'h0);
      check("areset OVF", 32'(ovf[g]), 32'h0);
    end
    @(negedge clk); rst_n = 1'b1;
    i0 = 16'd6; tick();
    check("restart acc", 32'(q[4]), 32'd6);
    check("restart VOUT", 32'(vout[4]), 32'h1);

    // Carry chain across two tiles
    vin = 1'b0;
    chain(32'h0000FFFF, 32'h00000001, 1'b0);
    check("chain lo cout", 32'(lo_cout), 32'h1);
    check("chain hi cout", 32'(hi_cout), 32'h0);
    check("chain word", {hi_q, lo_q}, 32'h00010000);
    for (int k = 0; k < 12; k++) chain($urandom, $urandom, 1'($urandom_range(0, 1)));

    // Random stream with occasional HOLD, ACLR and a mid-stream reset
    for (int k = 0; k < 600; k++) begin
      i0 = pick(); i1 = pick();
      cin = 1'($urandom_range(0, 1));
      vin = ($urandom_range(0, 3) != 0);
      ctrl = 8'($urandom);
      ctrl[3] = ($urandom_range(0, 6) == 0);
      ctrl[2] = ($urandom_range(0, 7) == 0);
      if (k == 300) begin
        @(posedge clk); #3; rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
      end else begin
        tick();
      end
    end
    vin = 1'b0; ctrl = 8'h00;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clbalup.md
# clbalup

Parametrised, pipelined successor to the fixed 16-bit CLB ALU primitive. It provides operand pass-through, add/sub and accumulate modes at configurable width, with valid tracking, a stall input, signed-overflow detection and optional saturation. It sits in the CLB datapath alongside the RAM and ALU tiles. COUT/CIN chain across adjacent tiles to form wider adders.

## Interface
Parameters:
- WIDTH, 16, datapath width in bits (4..64)
- MODE_ALU, 1, 0 = pass-through, 1 = add/sub, 2 = accumulate
- PIPE, 1, result latency in cycles (1 or 2)
- SAT, 0, 1 = saturate signed result on overflow (modes 1, 2)

Ports:
- C  input  1  clock, rising edge
- R  input  1  reset, asynchronous, active-low; one clock, no other clock domain
- I1  input  WIDTH  operand B
- I0  input  WIDTH  operand A
- CTRL  input  8  [0] SUB, [1] CINEN, [2] ACLR, [3] HOLD, [7:4] reserved, ignored
- CIN  input  1  carry in from the previous tile
- VIN  input  1  operands valid this cycle
- COUT  output  1  carry out of bit WIDTH-1
- OVF  output  1  signed overflow
- VOUT  output  1  Q/COUT/OVF valid
- Q  output  WIDTH  result

## Operation
- Effective carry-in: cin = CINEN ? CIN : SUB.
- Effective operand: b = SUB ? ~I1 : I1 (mode 1); a = SUB ? ~I0 : I0 (mode 2).
- Mode 0: Q = I0, COUT = 0, OVF = 0.
- Mode 1: {COUT, Q} = I0 + b + cin, computed at WIDTH+1 bits.
  - For subtract, COUT = 1 means no borrow.
  - OVF = (I0[MSB] == b[MSB]) && (sum[MSB] != I0[MSB]).
- Mode 2: acc_next = (ACLR ? 0 : acc) + a + cin.
  - Q = acc.
  - OVF is sticky: it sets on any overflow and clears only on an ACLR beat or reset.
  - COUT reflects the last beat only.
- SAT=1 on overflow: result = 0x7F..F if the true sign is positive, else 0x80..0.
  - In mode 2 the saturated value is what the accumulator stores.
- Stage-1 registers load only when VIN=1 and HOLD=0. When VIN=0 and HOLD=0, VOUT of the next stage is 0 and Q retains its last value.
- HOLD=1 freezes every register: pipeline, accumulator, VOUT and outputs. I*, CIN and VIN are ignored that cycle.
- PIPE=2 adds one output register stage with the same HOLD gating.
- Reserved CTRL bits have no effect. ACLR is ignored outside mode 2.

## Timing
- Reset (R=0): Q=0, COUT=0, OVF=0, VOUT=0, acc=0, every pipeline stage cleared.
  - Effect is immediate, without a clock edge.
  - This applies mid-operation too; in-flight beats are discarded.
- First edge after R rises behaves as a normal cycle.
- Latency: a beat sampled at edge N appears on Q/COUT/OVF/VOUT after edge N+PIPE-1+1. That is 1 edge for PIPE=1 and 2 edges for PIPE=2.
- Throughput: one beat per cycle when HOLD=0, with no bubbles inserted.
- Accumulate: back-to-back beats see the accumulator value updated by the previous beat, with no forwarding hazard.
- Mode 1 is fully pipelined. Mode 2 accumulates in stage 1; the PIPE=2 stage only delays the output.
- HOLD asserted at an edge: outputs at that edge are unchanged and resume on the first edge with HOLD=0.
- Simultaneous ACLR and HOLD: HOLD wins, and ACLR is lost unless it is re-presented.
- Wrap-around with SAT=0: modulo 2^WIDTH, with OVF flagged.

## Test plan
- **Add overflow.** Mode 1, WIDTH=16, PIPE=1, I0=0x7FFF, I1=0x0001, SUB=0, VIN=1.
  - SAT=0: next edge Q=0x8000, OVF=1, COUT=0, VOUT=1.
  - SAT=1: Q=0x7FFF.
- **Subtract with borrow.** I0=0x0005, I1=0x0007, SUB=1 -> Q=0xFFFE, COUT=0, OVF=0. Then I0=0x0009 -> Q=0x0002, COUT=1.
- **Accumulate.** Mode 2, beats I0=3 (ACLR=1), 4, 5 on consecutive cycles -> Q=3, 7, 12 on successive edges.
  - Then I0=0x7FFF -> OVF=1; OVF stays 1 until the next ACLR beat.
- **HOLD stall.** PIPE=2, stream 1, 2, 3, 4 with HOLD=1 for 3 cycles after beat 2.
  - Q/VOUT are frozen during HOLD.
  - Afterward Q sequence 1, 2, 3, 4 with no loss or duplication.
- **Async reset.** Drop R mid-stream between edges -> Q=0, VOUT=0, OVF=0 immediately.
  - After release, mode 2 restarts from acc=0.
- **Carry chain.** Two WIDTH=16 tiles, low COUT -> high CIN, high CINEN=1, add 0x0000FFFF + 0x00000001.
  - Result {hi, lo} = 0x00010000.
  - Low COUT=1, high COUT=0.
